mc_control_fsm: RTL and testbench

//  Multi-cycle MIPS control unit that owns its state register: sequences FETCH/DECODE/EXEC/MEM/WB/TRAP and drives datapath enables per state.

---
 rtl/mc_control_fsm_pkg.sv | 59 +++++
 rtl/mc_wait_timer.sv | 34 +++
 rtl/mc_control_fsm.sv | 178 +++++++++++++++++
 tb/tb_mc_control_fsm.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_control_fsm_pkg.sv
// rtl/mc_control_fsm_pkg.sv - opcode, funct, ALU, state and mux-select codes for the multi-cycle control unit
package mc_control_fsm_pkg;

  localparam int ALU_W = 3;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;

  localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUB_REG    = 2'b00;
  localparam logic [1:0] ALUB_FOUR   = 2'b01;
  localparam logic [1:0] ALUB_IMM    = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH = 2'b11;

  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OP_RTYPE: return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) || (fn == FN_OR);
      OP_J, OP_BEQ, OP_ADDI, OP_ORI, OP_LW, OP_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [ALU_W-1:0] funct_alu(input logic [5:0] fn);
    case (fn)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// rtl/mc_wait_timer.sv - memory wait counter and access-complete flag for FETCH/MEM
module mc_wait_timer #(
  parameter int MEM_HANDSHAKE = 1,
  parameter int MEM_LAT       = 1,
  parameter int LAT_W         = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic active,
  input  logic mem_ready,
  output logic mem_done
);

  localparam logic [LAT_W-1:0] LAST_CNT = LAT_W'(MEM_LAT - 1);

  logic [LAT_W-1:0] wait_cnt;

  assign mem_done = (MEM_HANDSHAKE != 0) ? mem_ready : (wait_cnt == LAST_CNT);

  // Completion means the FSM leaves the access state, so the count restarts there too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (en) begin
      if (active && !mem_done) begin
        wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multi-cycle MIPS control FSM with wait states, stall, trap and retire pulse
module mc_control_fsm
  import mc_control_fsm_pkg::*;
#(
  parameter int MEM_HANDSHAKE = 1,
  parameter int MEM_LAT       = 1,
  parameter int LAT_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [2:0]       state,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             ir_write,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [ALU_W-1:0] alu_op,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             retired,
  output logic             illegal
);

  state_t state_q;
  state_t state_nx;
  logic   illegal_q;
  logic   mem_done;
  logic   strobe_ok;

  logic             pc_write_c, ir_write_c, mem_write_c, reg_write_c, retired_c;
  logic             iord_c, mem_read_c, alu_src_a_c, reg_dst_c, mem_to_reg_c;
  logic [1:0]       pc_src_c, alu_src_b_c;
  logic [ALU_W-1:0] alu_op_c;

  mc_wait_timer #(
    .MEM_HANDSHAKE (MEM_HANDSHAKE),
    .MEM_LAT       (MEM_LAT),
    .LAT_W         (LAT_W)
  ) u_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .active    ((state_q == ST_FETCH) || (state_q == ST_MEM)),
    .mem_ready (mem_ready),
    .mem_done  (mem_done)
  );

  always_comb begin
    state_nx = state_q;
    case (state_q)
      ST_FETCH:  if (mem_done) state_nx = ST_DECODE;
      ST_DECODE: state_nx = is_legal(opcode, funct) ? ST_EXEC : ST_TRAP;
      ST_EXEC: begin
        case (opcode)
          OP_RTYPE, OP_ADDI, OP_ORI: state_nx = ST_WB;
          OP_LW, OP_SW:              state_nx = ST_MEM;
          OP_BEQ, OP_J:              state_nx = ST_FETCH;
          default:                   state_nx = ST_TRAP;
        endcase
      end
      ST_MEM:    if (mem_done) state_nx = (opcode == OP_LW) ? ST_WB : ST_FETCH;
      ST_WB:     state_nx = ST_FETCH;
      ST_TRAP:   state_nx = ST_TRAP;
      default:   state_nx = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      illegal_q <= 1'b0;
    end else if (en) begin
      state_q <= state_nx;
      if (state_nx == ST_TRAP) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    pc_write_c   = 1'b0;
    ir_write_c   = 1'b0;
    mem_write_c  = 1'b0;
    reg_write_c  = 1'b0;
    retired_c    = 1'b0;
    iord_c       = 1'b0;
    mem_read_c   = 1'b0;
    alu_src_a_c  = 1'b0;
    reg_dst_c    = 1'b0;
    mem_to_reg_c = 1'b0;
    pc_src_c     = PC_SRC_ALU;
    alu_src_b_c  = ALUB_REG;
    alu_op_c     = '0;
    case (state_q)
      ST_FETCH: begin
        mem_read_c  = 1'b1;
        alu_src_b_c = ALUB_FOUR;
        alu_op_c    = ALU_ADD;
        ir_write_c  = mem_done;
        pc_write_c  = mem_done;
      end
      ST_DECODE: begin
        alu_src_b_c = ALUB_IMM_SH;
        alu_op_c    = ALU_ADD;
      end
      ST_EXEC: begin
        case (opcode)
          OP_RTYPE: begin
            alu_src_a_c = 1'b1;
            alu_op_c    = funct_alu(funct);
          end
          OP_ADDI, OP_LW, OP_SW: begin
            alu_src_a_c = 1'b1;
            alu_src_b_c = ALUB_IMM;
            alu_op_c    = ALU_ADD;
          end
          OP_ORI: begin
            alu_src_a_c = 1'b1;
            alu_src_b_c = ALUB_IMM;
            alu_op_c    = ALU_OR;
          end
          OP_BEQ: begin
            alu_src_a_c = 1'b1;
            alu_op_c    = ALU_SUB;
            pc_src_c    = PC_SRC_ALUOUT;
            pc_write_c  = zero;
            retired_c   = 1'b1;
          end
          OP_J: begin
            pc_src_c   = PC_SRC_JUMP;
            pc_write_c = 1'b1;
            retired_c  = 1'b1;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        iord_c      = 1'b1;
        mem_read_c  = (opcode == OP_LW);
        mem_write_c = (opcode == OP_SW);
        retired_c   = (opcode == OP_SW) && mem_done;
      end
      ST_WB: begin
        reg_write_c  = 1'b1;
        retired_c    = 1'b1;
        reg_dst_c    = (opcode == OP_RTYPE);
        mem_to_reg_c = (opcode == OP_LW);
      end
      default: ;
    endcase
  end

  // Write strobes die with either reset or stall; selects only with reset.
  assign strobe_ok  = rst_n & en;
  assign pc_write   = strobe_ok & pc_write_c;
  assign ir_write   = strobe_ok & ir_write_c;
  assign mem_write  = strobe_ok & mem_write_c;
  assign reg_write  = strobe_ok & reg_write_c;
  assign retired    = strobe_ok & retired_c;
  assign iord       = rst_n & iord_c;
  assign mem_read   = rst_n & mem_read_c;
  assign alu_src_a  = rst_n & alu_src_a_c;
  assign reg_dst    = rst_n & reg_dst_c;
  assign mem_to_reg = rst_n & mem_to_reg_c;
  assign pc_src     = rst_n ? pc_src_c : 2'b00;
  assign alu_src_b  = rst_n ? alu_src_b_c : 2'b00;
  assign alu_op     = rst_n ? alu_op_c : '0;
  assign state      = state_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - self-checking bench: handshake and fixed-latency control units against an instruction-level model
module tb_mc_control_fsm;

  localparam int LAT1 = 3;
  localparam int P_FETCH = 0, P_DECODE = 1, P_EXEC = 2, P_MEM = 3, P_WB = 4, P_TRAP = 5;
  localparam int C_R = 0, C_ADDI = 1, C_ORI = 2, C_LW = 3, C_SW = 4, C_BEQ = 5, C_J = 6, C_ILL = 7;
  localparam logic [2:0] A_AND = 3'b000, A_OR = 3'b001, A_ADD = 3'b010, A_SUB = 3'b110;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [5:0] op [2];
  logic [5:0] fn [2];
  logic       zr [2];
  logic       rdy [2];
  logic       en_i [2];

  logic [2:0] st [2];
  logic [1:0] pcs [2];
  logic [1:0] sb [2];
  logic [2:0] aop [2];
  logic       pcw [2], irw [2], iod [2], mrd [2], mwr [2], sa [2];
  logic       rdst [2], m2r [2], rw [2], ret [2], ill [2];

  int  checks = 0;
  int  failures = 0;
  int  ph [2];
  int  wc [2];
  bit  il [2];
  bit  auto0 = 1'b0;
  bit  last_ret0;

  mc_control_fsm #(.MEM_HANDSHAKE(1), .MEM_LAT(1), .LAT_W(4)) u_hs (
    .clk(clk), .rst_n(rst_n), .en(en_i[0]), .opcode(op[0]), .funct(fn[0]), .zero(zr[0]),
    .mem_ready(rdy[0]), .state(st[0]), .pc_write(pcw[0]), .pc_src(pcs[0]), .ir_write(irw[0]),
    .iord(iod[0]), .mem_read(mrd[0]), .mem_write(mwr[0]), .alu_src_a(sa[0]), .alu_src_b(sb[0]),
    .alu_op(aop[0]), .reg_dst(rdst[0]), .mem_to_reg(m2r[0]), .reg_write(rw[0]),
    .retired(ret[0]), .illegal(ill[0])
  );

  mc_control_fsm #(.MEM_HANDSHAKE(0), .MEM_LAT(LAT1), .LAT_W(4)) u_lat (
    .clk(clk), .rst_n(rst_n), .en(en_i[1]), .opcode(op[1]), .funct(fn[1]), .zero(zr[1]),
    .mem_ready(rdy[1]), .state(st[1]), .pc_write(pcw[1]), .pc_src(pcs[1]), .ir_write(irw[1]),
    .iord(iod[1]), .mem_read(mrd[1]), .mem_write(mwr[1]), .alu_src_a(sa[1]), .alu_src_b(sb[1]),
    .alu_op(aop[1]), .reg_dst(rdst[1]), .mem_to_reg(m2r[1]), .reg_write(rw[1]),
    .retired(ret[1]), .illegal(ill[1])
  );

  function automatic int classify(input logic [5:0] o, input logic [5:0] f);
    case (o)
      6'h00:   return (f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h25) ? C_R : C_ILL;
      6'h08:   return C_ADDI;
      6'h0D:   return C_ORI;
      6'h23:   return C_LW;
      6'h2B:   return C_SW;
      6'h04:   return C_BEQ;
      6'h02:   return C_J;
      default: return C_ILL;
    endcase
  endfunction

  function automatic logic [2:0] r_alu(input logic [5:0] f);
    case (f)
      6'h22:   return A_SUB;
      6'h24:   return A_AND;
      6'h25:   return A_OR;
      default: return A_ADD;
    endcase
  endfunction

  function automatic logic mdone(input int k);
    return (k == 0) ? rdy[0] : (wc[1] == LAT1 - 1);
  endfunction

  function automatic logic [20:0] observed(input int k);
    return {st[k], pcw[k], pcs[k], irw[k], iod[k], mrd[k], mwr[k], sa[k], sb[k], aop[k],
            rdst[k], m2r[k], rw[k], ret[k], ill[k]};
  endfunction

  function automatic logic [20:0] expect_ctl(input int k);
    int c;
    logic d, e, pw, iw, io, mr, mw, a, rd, mt, w, rt;
    logic [1:0] ps, b;
    logic [2:0] ao;
    c = classify(op[k], fn[k]);
    d = mdone(k);
    e = en_i[k];
    {pw, iw, io, mr, mw, a, rd, mt, w, rt} = '0;
    ps = 2'b00; b = 2'b00; ao = 3'b000;
    if (!rst_n) return '0;
    case (ph[k])
      P_FETCH:  begin mr = 1; b = 2'b01; ao = A_ADD; pw = d & e; iw = d & e; end
      P_DECODE: begin b = 2'b11; ao = A_ADD; end
      P_EXEC: begin
        case (c)
          C_R:          begin a = 1; ao = r_alu(fn[k]); end
          C_ADDI, C_LW, C_SW: begin a = 1; b = 2'b10; ao = A_ADD; end
          C_ORI:        begin a = 1; b = 2'b10; ao = A_OR; end
          C_BEQ:        begin a = 1; ao = A_SUB; ps = 2'b01; pw = zr[k] & e; rt = e; end
          C_J:          begin ps = 2'b10; pw = e; rt = e; end
          default: ;
        endcase
      end
      P_MEM: begin io = 1; mr = (c == C_LW); mw = (c == C_SW) & e; rt = (c == C_SW) & d & e; end
      P_WB:  begin w = e; rt = e; rd = (c == C_R); mt = (c == C_LW); end
      default: ;
    endcase
    return {3'(ph[k]), pw, ps, iw, io, mr, mw, a, b, ao, rd, mt, w, rt, il[k]};
  endfunction

  task automatic model_step(input int k);
    int c, nxt;
    logic d;
    if (!rst_n) begin
      ph[k] = P_FETCH; wc[k] = 0; il[k] = 1'b0;
      return;
    end
    if (!en_i[k]) return;
    d = mdone(k);
    c = classify(op[k], fn[k]);
    nxt = ph[k];
    case (ph[k])
      P_FETCH:  if (d) nxt = P_DECODE;
      P_DECODE: nxt = (c == C_ILL) ? P_TRAP : P_EXEC;
      P_EXEC:   nxt = (c == C_R || c == C_ADDI || c == C_ORI) ? P_WB :
                      (c == C_LW || c == C_SW) ? P_MEM : P_FETCH;
      P_MEM:    if (d) nxt = (c == C_LW) ? P_WB : P_FETCH;
      P_WB:     nxt = P_FETCH;
      default:  nxt = P_TRAP;
    endcase
    if ((ph[k] == P_FETCH || ph[k] == P_MEM) && !d) wc[k]++;
    else wc[k] = 0;
    if (nxt == P_TRAP) il[k] = 1'b1;
    ph[k] = nxt;
  endtask

  task automatic auto_drive(input int k);
    int r;
    if (ph[k] == P_FETCH) begin
      r = $urandom_range(0, 39);
      fn[k] = 6'($urandom_range(0, 63));
      if (r == 0) begin
        op[k] = 6'h3F;
      end else if (r == 1) begin
        op[k] = 6'h00; fn[k] = 6'h2A;
      end else begin
        case ($urandom_range(0, 6))
          0: begin op[k] = 6'h00; fn[k] = 6'h20 + 6'(2 * $urandom_range(0, 1) + 4 * $urandom_range(0, 1)); end
          1: op[k] = 6'h08;
          2: op[k] = 6'h0D;
          3: op[k] = 6'h23;
          4: op[k] = 6'h2B;
          5: op[k] = 6'h04;
          default: op[k] = 6'h02;
        endcase
        if (op[k] == 6'h00 && fn[k] == 6'h26) fn[k] = 6'h25;
      end
    end
    zr[k]   = 1'($urandom_range(0, 1));
    rdy[k]  = ($urandom_range(0, 9) < 6);
    en_i[k] = ($urandom_range(0, 9) < 8);
  endtask

  task automatic tick();
    logic [20:0] o, x;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      o = observed(k);
      x = expect_ctl(k);
      checks++;
      assert (o === x) else begin
        failures++;
        $error("FAIL ctl%0d ph=%0d op=%h fn=%h observed=%h expected=%h", k, ph[k], op[k], fn[k], o, x);
      end
    end
    last_ret0 = ret[0];
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    auto_drive(1);
    if (auto0) auto_drive(0);
  endtask

  task automatic run0(input logic [5:0] o, input logic [5:0] f, input logic z,
                      input int mstall, input int estall, input int exp_cyc, input string tag);
    int cyc, ms, es;
    bit done;
    auto0 = 1'b0;
    op[0] = o; fn[0] = f; zr[0] = z;
    cyc = 0; ms = 0; es = 0; done = 1'b0;
    while (!done && cyc < 40) begin
      rdy[0] = 1'b1; en_i[0] = 1'b1;
      if (ph[0] == P_MEM && ms < mstall) begin
        rdy[0] = 1'b0; ms++;
      end else if (ph[0] == P_MEM && es < estall) begin
        en_i[0] = 1'b0; es++;
      end
      tick();
      cyc++;
      done = last_ret0;
    end
    checks++;
    assert (done && cyc == exp_cyc) else begin
      failures++;
      $error("FAIL %s cycles=%0d retired=%0b expected cycles=%0d", tag, cyc, done, exp_cyc);
    end
  endtask

  task automatic check_trap(input logic [5:0] o, input logic [5:0] f, input string tag);
    op[0] = o; fn[0] = f; rdy[0] = 1'b1; en_i[0] = 1'b1; zr[0] = 1'b0;
    repeat (3) tick();
    op[0] = 6'h02;
    repeat (4) tick();
    checks++;
    assert (st[0] === 3'd5 && ill[0] === 1'b1) else begin
      failures++;
      $error("FAIL %s state=%0d illegal=%0b expected state=5 illegal=1", tag, st[0], ill[0]);
    end
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) tick();
    checks++;
    assert (st[0] === 3'd0 && ill[0] === 1'b0 && mrd[0] === 1'b0 && mrd[1] === 1'b0) else begin
      failures++;
      $error("FAIL in_reset state=%0d illegal=%0b mem_read=%0b/%0b expected 0,0,0/0", st[0], ill[0], mrd[0], mrd[1]);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      ph[k] = P_FETCH; wc[k] = 0; il[k] = 1'b0;
      op[k] = 6'h00; fn[k] = 6'h20; zr[k] = 1'b0; rdy[k] = 1'b1; en_i[k] = 1'b1;
    end
    auto_drive(1);
    do_reset(2);

    run0(6'h00, 6'h20, 1'b0, 0, 0, 4, "add");
    run0(6'h00, 6'h22, 1'b0, 0, 0, 4, "sub");
    run0(6'h0D, 6'h00, 1'b0, 0, 0, 4, "ori");
    run0(6'h23, 6'h00, 1'b0, 3, 0, 8, "lw_wait3");
    run0(6'h04, 6'h00, 1'b1, 0, 0, 3, "beq_taken");
    run0(6'h04, 6'h00, 1'b0, 0, 0, 3, "beq_not_taken");
    run0(6'h2B, 6'h00, 1'b0, 0, 2, 6, "sw_stall2");
    run0(6'h02, 6'h00, 1'b0, 0, 0, 3, "jump");
    run0(6'h08, 6'h00, 1'b0, 0, 0, 4, "addi");

    check_trap(6'h3F, 6'h00, "trap_opcode");
    do_reset(1);
    check_trap(6'h00, 6'h2A, "trap_funct");
    do_reset(1);

    op[0] = 6'h23; rdy[0] = 1'b1; en_i[0] = 1'b1;
    for (int i = 0; i < 10 && ph[0] != P_MEM; i++) tick();
    rdy[0] = 1'b0;
    tick();
    do_reset(2);
    run0(6'h00, 6'h24, 1'b0, 0, 0, 4, "refetch_after_reset");

    auto0 = 1'b1;
    auto_drive(0);
    for (int i = 0; i < 3000; i++) begin
      rst_n = !(($urandom_range(0, 149) == 0) || (ph[0] == P_TRAP && ph[1] == P_TRAP));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
